// File: rtl/note_event_tx.sv
// Converts per-note sustained levels into a serial stream of note-on/off events.
// Events queue per lane and are emitted round-robin over a valid/ready handshake.
module note_event_tx #(
  parameter int NOTES = 25,
  parameter int IDX_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic [NOTES-1:0] i_note,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_on,
  output logic             o_pending
);

  logic [NOTES-1:0] prev_q, prev_d;
  logic [NOTES-1:0] pend_q, pend_d;
  logic [NOTES-1:0] kind_q, kind_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             out_vld_q, out_vld_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic             out_on_q, out_on_d;

  logic [NOTES-1:0] rise, fall;
  logic             load;
  logic             found;
  logic [IDX_W-1:0] sel;

  assign rise = i_note & ~prev_q;
  assign fall = ~i_note & prev_q;
  assign load = !out_vld_q || i_ready;
  assign prev_d = i_note;

  // First pending lane at or after ptr_q, wrapping at NOTES-1.
  always_comb begin
    logic [IDX_W:0] sum;
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    found = 1'b0;
    sel   = '0;
    sum   = '0;
    for (int i = 0; i < NOTES; i++) begin
      sum = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NOTES)) sum = sum - (IDX_W+1)'(NOTES);
      if (!found && pend_q[sum[IDX_W-1:0]]) begin
        found = 1'b1;
        sel   = sum[IDX_W-1:0];
      end
    end
  end

  // Loaded lane is cleared first so a same-cycle edge re-queues as a new event.
  always_comb begin
    pend_d = pend_q;
    kind_d = kind_q;
    if (load && found) pend_d[sel] = 1'b0;
    for (int i = 0; i < NOTES; i++) begin
      if (rise[i] || fall[i]) begin
        if (!pend_d[i]) begin
          pend_d[i] = 1'b1;
          kind_d[i] = rise[i];
        end else begin
          pend_d[i] = 1'b0;
        end
      end
    end
    if (i_clear) pend_d = '0;
  end

  always_comb begin
    out_vld_d = out_vld_q;
    out_idx_d = out_idx_q;
    out_on_d  = out_on_q;
    ptr_d     = ptr_q;
    if (load) begin
      out_vld_d = found;
      if (found) begin
        out_idx_d = sel;
        out_on_d  = kind_q[sel];
        ptr_d     = (sel == IDX_W'(NOTES-1)) ? '0 : sel + IDX_W'(1);
      end
    end
    if (i_clear) begin
      out_vld_d = 1'b0;
      ptr_d     = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev_q    <= '0;
      pend_q    <= '0;
      kind_q    <= '0;
      ptr_q     <= '0;
      out_vld_q <= 1'b0;
      out_idx_q <= '0;
      out_on_q  <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      pend_q    <= pend_d;
      kind_q    <= kind_d;
      ptr_q     <= ptr_d;
      out_vld_q <= out_vld_d;
      out_idx_q <= out_idx_d;
      out_on_q  <= out_on_d;
    end
  end

  assign o_valid   = out_vld_q;
  assign o_idx     = out_idx_q;
  assign o_on      = out_on_q;
  assign o_pending = |pend_q;

endmodule

// File: tb/tb_note_event_tx.sv
// Scoreboard bench for note_event_tx: directed level changes push expected
// events; a negedge monitor pops and compares every accepted transfer.
module tb_note_event_tx;
  localparam int NOTES = 25;
  localparam int IDX_W = 5;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             on;
  } ev_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic             ready = 1'b0;
  logic [NOTES-1:0] note = '0;
  logic             valid, on, pending;
  logic [IDX_W-1:0] idx;

  ev_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;

  always #5 clk = ~clk;

  note_event_tx #(.NOTES(NOTES), .IDX_W(IDX_W)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_clear  (clear),
    .i_note   (note),
    .o_valid  (valid),
    .i_ready  (ready),
    .o_idx    (idx),
    .o_on     (on),
    .o_pending(pending)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_ev(input int lane, input logic kind);
    ev_t e;
    e.idx = IDX_W'(lane);
    e.on  = kind;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || valid) && t < 60) begin
      tick();
      t++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // A transfer happens at the next posedge when valid && ready at the negedge.
  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event: got idx=%0d on=%0d, want none", idx, on);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (idx !== e.idx || on !== e.on) begin
          n_err++;
          $display("FAIL event: got idx=%0d on=%0d, want idx=%0d on=%0d", idx, on, e.idx, e.on);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("rst_valid", valid, 0);
    check("rst_idx", idx, 0);
    check("rst_on", on, 0);
    check("rst_pending", pending, 0);
    tick(2);
    rst_n = 1'b1;
    ready = 1'b1;
    tick();

    // Single rise: two-cycle latency, held for exactly one cycle.
    note[3] = 1'b1;
    expect_ev(3, 1'b1);
    tick();
    check("t1_not_yet", valid, 0);
    tick();
    check("t1_valid", valid, 1);
    check("t1_idx", idx, 3);
    check("t1_on", on, 1);
    tick();
    check("t1_one_cycle", valid, 0);

    // Three simultaneous rises from ptr 0: ascending order, ptr wraps.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    note[0] = 1'b1; note[5] = 1'b1; note[24] = 1'b1;
    expect_ev(0, 1'b1); expect_ev(5, 1'b1); expect_ev(24, 1'b1);
    tick(2);
    check("t2_first", idx, 0);
    tick();
    check("t2_second", idx, 5);
    tick();
    check("t2_third", idx, 24);
    drain("t2_drain");
    // ptr wrapped to 0, so lane 23 precedes lane 24.
    note[23] = 1'b1; note[24] = 1'b0;
    expect_ev(23, 1'b1); expect_ev(24, 1'b0);
    drain("t2_wrap_drain");

    // Stalled output stays stable while its lane falls.
    note = '0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t3_clear_valid", valid, 0);
    check("t3_clear_pending", pending, 0);
    ready = 1'b0;
    note[5] = 1'b1;
    tick(2);
    check("t3_valid", valid, 1);
    check("t3_idx", idx, 5);
    note[5] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_hold_valid", valid, 1);
      check("t3_hold_ev", {idx, on}, {5'd5, 1'b1});
      check("t3_hold_pending", pending, 1);
    end
    expect_ev(5, 1'b1); expect_ev(5, 1'b0);
    ready = 1'b1;
    drain("t3_drain");

    // One-cycle pulse on lane 7 cancels while output is blocked.
    ready = 1'b0;
    note[10] = 1'b1;
    tick(2);
    check("t4_idx", idx, 10);
    note[7] = 1'b1;
    tick();
    check("t4_pulse_pending", pending, 1);
    note[7] = 1'b0;
    tick();
    check("t4_cancel_pending", pending, 0);
    check("t4_hold_ev", {valid, idx, on}, {1'b1, 5'd10, 1'b1});
    expect_ev(10, 1'b1);
    ready = 1'b1;
    drain("t4_drain");

    // Lanes 2 and 20 toggled every two cycles; ptr starts at 11 so 20 leads.
    for (int j = 0; j < 6; j++) begin
      note[2]  = ~note[2];
      note[20] = ~note[20];
      expect_ev(20, (j % 2) == 0);
      expect_ev(2,  (j % 2) == 0);
      tick(2);
    end
    drain("t5_drain");

    // Flush with everything high and events pending.
    ready = 1'b0;
    note = '1;
    tick(3);
    check("t6_valid_before", valid, 1);
    check("t6_pending_before", pending, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t6_valid_after", valid, 0);
    check("t6_pending_after", pending, 0);
    ready = 1'b1;
    tick(5);
    check("t6_quiet", valid, 0);
    note[12] = 1'b0;
    expect_ev(12, 1'b0);
    tick();
    check("t6_latency", valid, 0);
    drain("t6_drain");

    // Asynchronous reset drops o_valid without a clock.
    ready = 1'b0;
    note[12] = 1'b1;
    tick(2);
    check("rst_mid_valid", valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_drop", valid, 0);
    check("rst_mid_pending", pending, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
